// File: rtl/eth_tx_arbiter.sv
// Round-robin, frame-granular arbiter sharing the Ethernet byte-write port between NREQ sources.
// Optional stall timeout/abort is enabled by defining TX_TIMEOUT_EN.
//
// state | meaning
// IDLE  | sample i_req, pick next requester after ptr, register one-hot grant
// BUSY  | granted source drives the port until its i_last byte is accepted
// GAP   | forced inter-frame gap of IFG cycles, no grant
module eth_tx_arbiter #(
  parameter int NREQ    = 3,
  parameter int IFG     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req,
  input  logic [8*NREQ-1:0] i_data,
  input  logic [NREQ-1:0]   i_valid,
  input  logic [NREQ-1:0]   i_last,
  output logic [NREQ-1:0]   o_ready,
  output logic [NREQ-1:0]   o_grant,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_abort,
  output logic [7:0]        o_wdata,
  input  logic              i_wready,
  output logic              o_wvalid
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [GW-1:0]   GAP_LOAD = GW'((IFG > 0) ? IFG - 1 : 0);
  localparam logic [NREQ-1:0] ONE      = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] grant_q, grant_nxt;
  logic [PW-1:0]   ptr_q, ptr_nxt;
  logic [GW-1:0]   gap_cnt, gap_nxt;

  logic [7:0]      wdata_g;
  logic            valid_g;
  logic            last_g;
  logic            busy;
  logic            xfer;
  logic            found;
  logic [PW-1:0]   win;

  // ptr always holds the granted index while in BUSY, so it doubles as the mux select
  always_comb begin
    wdata_g = 8'd0;
    valid_g = 1'b0;
    last_g  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (ptr_q == PW'(k)) begin
        wdata_g = i_data[8*k +: 8];
        valid_g = i_valid[k];
        last_g  = i_last[k];
      end
    end
  end

  assign busy     = (state == BUSY);
  assign o_busy   = busy;
  assign o_grant  = grant_q;
  assign o_wvalid = busy & valid_g;
  assign o_wdata  = busy ? wdata_g : 8'd0;
  assign o_ready  = (busy & i_wready) ? grant_q : '0;
  assign xfer     = o_wvalid & i_wready;
  assign o_done   = xfer & last_g;

  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && i_req[(int'(ptr_q) + i) % NREQ]) begin
        found = 1'b1;
        win   = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam logic [7:0] STALL_LIM = 8'(TIMEOUT - 1);
  logic [7:0] stall_cnt, stall_nxt;
  logic       abort_q, abort_nxt;
  assign o_abort = abort_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT);
  assign o_abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    ptr_nxt   = ptr_q;
    gap_nxt   = gap_cnt;
`ifdef TX_TIMEOUT_EN
    stall_nxt = stall_cnt;
    abort_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = ONE << win;
          ptr_nxt   = win;
          state_nxt = BUSY;
`ifdef TX_TIMEOUT_EN
          stall_nxt = 8'd0;
`endif
        end
      end
      BUSY: begin
        if (o_done) begin
          grant_nxt = '0;
          gap_nxt   = GAP_LOAD;
          state_nxt = (IFG == 0) ? IDLE : GAP;
        end
`ifdef TX_TIMEOUT_EN
        else if (xfer) begin
          stall_nxt = 8'd0;
        end else if (stall_cnt == STALL_LIM) begin
          // ptr already points at the stalled source, so it loses its turn
          abort_nxt = 1'b1;
          grant_nxt = '0;
          gap_nxt   = GAP_LOAD;
          state_nxt = (IFG == 0) ? IDLE : GAP;
        end else begin
          stall_nxt = stall_cnt + 8'd1;
        end
`endif
      end
      GAP: begin
        if (gap_cnt == '0) state_nxt = IDLE;
        else gap_nxt = gap_cnt - GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NREQ - 1);
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      ptr_q   <= ptr_nxt;
      gap_cnt <= gap_nxt;
    end
  end

`ifdef TX_TIMEOUT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt <= 8'd0;
      abort_q   <= 1'b0;
    end else begin
      stall_cnt <= stall_nxt;
      abort_q   <= abort_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized bench for eth_tx_arbiter: queued frame sources, a frame-level round-robin
// reference model and per-cycle port checks.
module tb_eth_tx_arbiter;
  localparam int NREQ    = 3;
  localparam int IFG     = 2;
  localparam int TIMEOUT = 4;
`ifdef TX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [NREQ-1:0]   i_req, i_valid, i_last, o_ready, o_grant;
  logic [8*NREQ-1:0] i_data;
  logic              o_busy, o_done, o_abort, o_wvalid, i_wready;
  logic [7:0]        o_wdata;

  always #5 i_clk = ~i_clk;

  eth_tx_arbiter #(.NREQ(NREQ), .IFG(IFG), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_data(i_data),
    .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready), .o_grant(o_grant),
    .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort), .o_wdata(o_wdata),
    .i_wready(i_wready), .o_wvalid(o_wvalid)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // per-source frame stores
  logic [7:0] bmem [NREQ][1024];
  int flen [NREQ][256];
  int bwr [NREQ], brd [NREQ], fwr [NREQ], frd [NREQ], sent [NREQ];
  bit mute [NREQ], drop [NREQ];
  int valid_pct = 100;
  bit wr_rand   = 1'b0;
  bit wr_pat [$];

  // reference model state
  int cur = -1, last_src = NREQ - 1, earliest = 0, stall = 0, abort_cyc = -1;
  logic [NREQ-1:0] prev_req = '0;
  int start_q [$];
  logic [7:0] obs_q [$];

  function automatic bit pending(input int k);
    return frd[k] != fwr[k];
  endfunction

  function automatic bit any_pending();
    for (int k = 0; k < NREQ; k++) if (pending(k)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int i = 1; i <= NREQ; i++) if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    return -1;
  endfunction

  task automatic add_frame(input int k, input int len, input int base);
    for (int i = 0; i < len; i++) begin
      bmem[k][bwr[k] % 1024] = (base < 0) ? 8'($urandom) : 8'(base + i);
      bwr[k]++;
    end
    flen[k][fwr[k] % 256] = len;
    fwr[k]++;
  endtask

  task automatic pop_byte(input int k);
    brd[k]++;
    sent[k]++;
    if (sent[k] == flen[k][frd[k] % 256]) begin
      frd[k]++;
      sent[k] = 0;
      drop[k] = 1'b0;
    end
  endtask

  task automatic drop_frame(input int k);
    if (pending(k)) begin
      brd[k] += flen[k][frd[k] % 256] - sent[k];
      frd[k]++;
      sent[k] = 0;
      drop[k] = 1'b0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      bit p;
      p = pending(k);
      i_req[k]         = p && !(drop[k] && sent[k] > 0);
      i_valid[k]       = p && !mute[k] && ($urandom_range(99) < valid_pct);
      i_data[8*k +: 8] = p ? bmem[k][brd[k] % 1024] : 8'd0;
      i_last[k]        = p && (sent[k] == flen[k][frd[k] % 256] - 1);
    end
    if (wr_pat.size() > 0) i_wready = wr_pat.pop_front();
    else if (wr_rand)      i_wready = ($urandom_range(3) != 0);
    else                   i_wready = 1'b1;
  endtask

  task automatic monitor();
    logic [NREQ-1:0] exp_g;
    bit xf, lst;
    cyc++;
    if (i_rst) begin
      if (cur >= 0) drop_frame(cur);
      cur       = -1;
      last_src  = NREQ - 1;
      earliest  = cyc + 2;
      stall     = 0;
      abort_cyc = -1;
      prev_req  = i_req;
      return;
    end
    chk("abort", 32'(o_abort), 32'(cyc == abort_cyc));
    if (cur < 0) begin
      if (cyc >= earliest && prev_req != '0) begin
        cur      = rr_pick(prev_req, last_src);
        last_src = cur;
        stall    = 0;
        start_q.push_back(cur);
      end else begin
        chk("idle_outs", 32'({o_grant, o_busy, o_wvalid, o_ready, o_done, o_wdata}), 32'd0);
      end
    end
    if (cur >= 0) begin
      exp_g = NREQ'(1) << cur;
      chk("grant", 32'(o_grant), 32'(exp_g));
      chk("busy", 32'(o_busy), 32'd1);
      chk("wvalid", 32'(o_wvalid), 32'(i_valid[cur]));
      chk("wdata", 32'(o_wdata), 32'(i_data[8*cur +: 8]));
      chk("ready", 32'(o_ready), i_wready ? 32'(exp_g) : 32'd0);
      xf  = i_valid[cur] && i_wready;
      lst = xf && i_last[cur];
      chk("done", 32'(o_done), 32'(lst));
      if (xf) begin
        obs_q.push_back(i_data[8*cur +: 8]);
        pop_byte(cur);
        stall = 0;
        if (lst) begin
          cur      = -1;
          earliest = cyc + IFG + 2;
        end
      end else if (TMO_EN) begin
        stall++;
        if (stall == TIMEOUT) begin
          drop_frame(cur);
          cur       = -1;
          earliest  = cyc + IFG + 2;
          abort_cyc = cyc + 1;
        end
      end
    end
    prev_req = i_req;
  endtask

  task automatic step();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    #1;
    drive();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((any_pending() || cur >= 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_bound", 32'(n >= max_cyc), 32'd0);
    repeat (IFG + 3) step();
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic chk_list(input string tag, input int got [$], input int exp [$]);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(tag, 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    int got [$];
    int n;
    i_rst = 1'b1;
    i_req = '0; i_valid = '0; i_last = '0; i_data = '0; i_wready = 1'b1;
    repeat (3) step();
    chk("reset_outs", 32'({o_grant, o_busy, o_done, o_abort, o_wvalid, o_ready, o_wdata}), 32'd0);
    i_rst = 1'b0;

    // single 4-byte frame from source 0
    obs_q.delete(); start_q.delete();
    add_frame(0, 4, 'hA0);
    drain(100);
    got.delete(); foreach (obs_q[i]) got.push_back(int'(obs_q[i]));
    chk_list("t1_bytes", got, '{'hA0, 'hA1, 'hA2, 'hA3});
    chk_list("t1_order", start_q, '{0});

    // all three requesting, two 2-byte frames each
    do_reset();
    start_q.delete();
    for (int r = 0; r < 2; r++) for (int k = 0; k < NREQ; k++) add_frame(k, 2, -1);
    drain(200);
    chk_list("t2_order", start_q, '{0, 1, 2, 0, 1, 2});

    // wready stalls in the middle of source 1's frame
    obs_q.delete(); start_q.delete();
    add_frame(1, 3, 'h30);
    wr_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drain(100);
    got.delete(); foreach (obs_q[i]) got.push_back(int'(obs_q[i]));
    chk_list("t3_bytes", got, '{'h30, 'h31, 'h32});

    // source 0 drops i_req after its first byte; frame must still complete
    obs_q.delete(); start_q.delete();
    drop[0] = 1'b1;
    add_frame(0, 3, 'h40);
    step();
    add_frame(2, 2, 'h50);
    drain(100);
    got.delete(); foreach (obs_q[i]) got.push_back(int'(obs_q[i]));
    chk_list("t4_bytes", got, '{'h40, 'h41, 'h42, 'h50, 'h51});
    chk_list("t4_order", start_q, '{0, 2});

    // reset during the second byte of a frame
    add_frame(1, 1, -1);
    drain(50);
    add_frame(0, 4, 'h60);
    n = 0;
    while (sent[0] != 1 && n < 50) begin
      step();
      n++;
    end
    chk("t5_reach_byte2", 32'(n >= 50), 32'd0);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("t5_rst_outs", 32'({o_grant, o_wvalid, o_busy}), 32'd0);
    start_q.delete();
    for (int k = 0; k < NREQ; k++) add_frame(k, 2, -1);
    drain(100);
    chk_list("t5_order", start_q, '{0, 1, 2});

    // source 1 granted but never presents a byte
    do_reset();
    start_q.delete();
    mute[1] = 1'b1;
    add_frame(1, 2, 'h70);
    add_frame(2, 2, 'h80);
    repeat (120) step();
`ifdef TX_TIMEOUT_EN
    chk_list("t6_order", start_q, '{1, 2});
    mute[1] = 1'b0;
    drain(50);
`else
    chk("t6_hold_grant", 32'(o_grant), 32'b010);
    chk_list("t6_held", start_q, '{1});
    mute[1] = 1'b0;
    drain(100);
    chk_list("t6_order", start_q, '{1, 2});
`endif

    // random traffic
    start_q.delete();
    valid_pct = 75;
    wr_rand   = 1'b1;
    for (int i = 0; i < 40; i++) add_frame(int'($urandom_range(NREQ - 1)), int'($urandom_range(6, 1)), -1);
    drain(5000);
    chk("t7_frames", 32'(start_q.size()), 32'd40);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
